// File: rtl/mlam_stream_pkg.sv
// rtl/mlam_stream_pkg.sv - shared types, lane helpers and reference product model
package mlam_stream_pkg;

  localparam int MAX_W   = 16;
  localparam int MAX_BUS = 256;

  localparam logic MODE_EXACT  = 1'b0;
  localparam logic MODE_APPROX = 1'b1;

  // Majority of three; with z=0 it is AND, with z=1 it is OR.
  function automatic logic maj3(input logic x, input logic y, input logic z);
    return (x & y) | (x & z) | (y & z);
  endfunction

  // Extract lane `lane` of width `w` from a packed bus (zero-extended to MAX_W).
  function automatic logic [MAX_W-1:0] lane_get(input logic [MAX_BUS-1:0] bus,
                                                input int lane, input int w);
    logic [MAX_BUS-1:0] sh;
    logic [MAX_W-1:0]   r;
    sh = bus >> (lane * w);
    r  = '0;
    for (int i = 0; i < MAX_W; i++) begin
      if (i < w) r[i] = sh[i];
    end
    return r;
  endfunction

  // Upper half of a 2*w-bit lane product.
  function automatic logic [MAX_W-1:0] lane_msb(input logic [2*MAX_W-1:0] p, input int w);
    logic [MAX_W-1:0] r;
    r = '0;
    for (int i = 0; i < MAX_W; i++) begin
      if (i < w) r[i] = p[i+w];
    end
    return r;
  endfunction

  // Column-wise reference: columns below k collapse to an OR, the rest keep
  // their exact weighted popcount. k=0 gives the exact product.
  function automatic logic [2*MAX_W-1:0] approx_mult(input logic [MAX_W-1:0] a,
                                                     input logic [MAX_W-1:0] b,
                                                     input int k);
    logic [2*MAX_W-1:0] p;
    int cnt;
    p = '0;
    for (int n = 0; n < 2*MAX_W; n++) begin
      cnt = 0;
      for (int i = 0; i < MAX_W; i++) begin
        if ((n - i) >= 0 && (n - i) < MAX_W) begin
          if (a[i] && b[n-i]) cnt++;
        end
      end
      if (n < k) p[n] = (cnt != 0);
      else       p = p + ((2*MAX_W)'(cnt) << n);
    end
    return p;
  endfunction

endpackage

// File: rtl/mlam_lor_lane.sv
// rtl/mlam_lor_lane.sv - combinational exact / lower-part-OR lane multiplier
module mlam_lor_lane
  import mlam_stream_pkg::*;
#(
  parameter int WIDTH       = 8,
  parameter int APPROX_COLS = 8
) (
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  input  logic               mode,
  output logic [2*WIDTH-1:0] p
);

  localparam int PW = 2 * WIDTH;

  logic [PW-1:0] hi_sum;
  logic [PW-1:0] lo_or;
  logic [PW-1:0] exact_p;
  logic          pp;

  // Split the partial-product array: low columns OR together, high columns add exactly.
  always_comb begin
    hi_sum = '0;
    lo_or  = '0;
    pp     = 1'b0;
    for (int i = 0; i < WIDTH; i++) begin
      for (int j = 0; j < WIDTH; j++) begin
        pp = maj3(a[i], b[j], 1'b0);
        if ((i + j) < APPROX_COLS) lo_or[i+j] = maj3(lo_or[i+j], pp, 1'b1);
        else                       hi_sum = hi_sum + (PW'(pp) << (i + j));
      end
    end
  end

  assign exact_p = PW'(a) * PW'(b);

  // The two parts occupy disjoint bit ranges, so OR is the same as add here.
  assign p = (mode == MODE_APPROX) ? (hi_sum | lo_or) : exact_p;

endmodule

// File: rtl/mlam_stream_mult.sv
// rtl/mlam_stream_mult.sv - two-stage back-pressurable multi-lane multiplier
module mlam_stream_mult
  import mlam_stream_pkg::*;
#(
  parameter int WIDTH       = 8,
  parameter int CHANNELS    = 3,
  parameter int APPROX_COLS = 8,
  parameter int CNT_W       = 32
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          in_valid,
  output logic                          in_ready,
  input  logic [CHANNELS*WIDTH-1:0]     in_a,
  input  logic [CHANNELS*WIDTH-1:0]     in_b,
  input  logic                          in_mode,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic [CHANNELS*2*WIDTH-1:0]   out_p,
  output logic [CHANNELS*WIDTH-1:0]     out_msb,
  output logic                          out_mode,
  output logic [CNT_W-1:0]              txn_count
);

  localparam int LW = CHANNELS * WIDTH;
  localparam int PW = 2 * WIDTH;

  logic          s1_valid_q, s1_valid_d;
  logic [LW-1:0] s1_a_q, s1_a_d;
  logic [LW-1:0] s1_b_q, s1_b_d;
  logic          s1_mode_q, s1_mode_d;

  logic                   s2_valid_q, s2_valid_d;
  logic [CHANNELS*PW-1:0] s2_p_q, s2_p_d;
  logic                   s2_mode_q, s2_mode_d;

  logic [CNT_W-1:0] txn_q, txn_d;

  logic                   s2_advance;
  logic                   s2_load;
  logic                   in_fire;
  logic                   out_fire;
  logic [CHANNELS*PW-1:0] lane_p_bus;

  // S2 frees up when it is empty or its beat leaves; S1 rides on that.
  assign s2_advance = !s2_valid_q || out_ready;
  assign in_ready   = !s1_valid_q || s2_advance;
  assign in_fire    = in_valid && in_ready;
  assign s2_load    = s2_advance && s1_valid_q;
  assign out_fire   = s2_valid_q && out_ready;

  for (genvar c = 0; c < CHANNELS; c++) begin : g_lane
    logic [WIDTH-1:0] la;
    logic [WIDTH-1:0] lb;
    logic [PW-1:0]    lp;

    assign la = WIDTH'(lane_get(MAX_BUS'(s1_a_q), c, WIDTH));
    assign lb = WIDTH'(lane_get(MAX_BUS'(s1_b_q), c, WIDTH));

    mlam_lor_lane #(
      .WIDTH      (WIDTH),
      .APPROX_COLS(APPROX_COLS)
    ) u_lane (
      .a   (la),
      .b   (lb),
      .mode(s1_mode_q),
      .p   (lp)
    );

    assign lane_p_bus[c*PW +: PW] = lp;
    assign out_msb[c*WIDTH +: WIDTH] = WIDTH'(lane_msb((2*MAX_W)'(s2_p_q[c*PW +: PW]), WIDTH));

    // Cross-check every lane product against the column reference as S2 captures it.
    always_ff @(posedge clk) begin
      if (!rst && s2_load) begin
        assert (lp == PW'(approx_mult(MAX_W'(la), MAX_W'(lb),
                                      (s1_mode_q == MODE_APPROX) ? APPROX_COLS : 0)));
      end
    end
  end

  // Next-state for both stages and the delivered-beat counter.
  always_comb begin
    s1_valid_d = s1_valid_q;
    s1_a_d     = s1_a_q;
    s1_b_d     = s1_b_q;
    s1_mode_d  = s1_mode_q;
    s2_valid_d = s2_valid_q;
    s2_p_d     = s2_p_q;
    s2_mode_d  = s2_mode_q;
    txn_d      = txn_q + CNT_W'(out_fire);

    if (in_ready) begin
      s1_valid_d = in_valid;
      if (in_fire) begin
        s1_a_d    = in_a;
        s1_b_d    = in_b;
        s1_mode_d = in_mode;
      end
    end

    if (s2_advance) begin
      s2_valid_d = s1_valid_q;
      if (s1_valid_q) begin
        s2_p_d    = lane_p_bus;
        s2_mode_d = s1_mode_q;
      end
    end
  end

  // Pipeline registers; reset drops every in-flight beat.
  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid_q <= 1'b0;
      s1_a_q     <= '0;
      s1_b_q     <= '0;
      s1_mode_q  <= 1'b0;
      s2_valid_q <= 1'b0;
      s2_p_q     <= '0;
      s2_mode_q  <= 1'b0;
      txn_q      <= '0;
    end else begin
      s1_valid_q <= s1_valid_d;
      s1_a_q     <= s1_a_d;
      s1_b_q     <= s1_b_d;
      s1_mode_q  <= s1_mode_d;
      s2_valid_q <= s2_valid_d;
      s2_p_q     <= s2_p_d;
      s2_mode_q  <= s2_mode_d;
      txn_q      <= txn_d;
    end
  end

  assign out_valid = s2_valid_q;
  assign out_p     = s2_p_q;
  assign out_mode  = s2_mode_q;
  assign txn_count = txn_q;

endmodule

// File: tb/tb_mlam_stream_mult.sv
// tb/tb_mlam_stream_mult.sv - randomized scoreboard bench across K=0..15
module tb_mlam_stream_mult;
  import mlam_stream_pkg::*;

  localparam int W    = 8;
  localparam int CH   = 3;
  localparam int NK   = 16;
  localparam int LW   = CH * W;
  localparam int PBW  = CH * 2 * W;
  localparam int MAIN = 8;

  logic          clk = 1'b0;
  logic          rst;
  logic          in_valid;
  logic          in_mode;
  logic          out_ready;
  logic [LW-1:0] in_a;
  logic [LW-1:0] in_b;

  logic           in_ready_k  [NK];
  logic           out_valid_k [NK];
  logic [PBW-1:0] out_p_k     [NK];
  logic [LW-1:0]  out_msb_k   [NK];
  logic           out_mode_k  [NK];
  logic [31:0]    txn_k       [NK];

  always #5 clk = ~clk;

  for (genvar k = 0; k < NK; k++) begin : g_dut
    mlam_stream_mult #(
      .WIDTH      (W),
      .CHANNELS   (CH),
      .APPROX_COLS(k),
      .CNT_W      (32)
    ) u_dut (
      .clk      (clk),
      .rst      (rst),
      .in_valid (in_valid),
      .in_ready (in_ready_k[k]),
      .in_a     (in_a),
      .in_b     (in_b),
      .in_mode  (in_mode),
      .out_valid(out_valid_k[k]),
      .out_ready(out_ready),
      .out_p    (out_p_k[k]),
      .out_msb  (out_msb_k[k]),
      .out_mode (out_mode_k[k]),
      .txn_count(txn_k[k])
    );
  end

  typedef struct packed {
    logic [LW-1:0] a;
    logic [LW-1:0] b;
    logic          mode;
  } beat_t;

  beat_t          exp_q[$];
  int             n_checks = 0;
  int             n_fail   = 0;
  int             txn_exp  = 0;
  int             accepts  = 0;
  logic           hold_prev = 1'b0;
  logic [PBW-1:0] prev_p;
  logic           prev_mode;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [PBW-1:0] model_p(input logic [LW-1:0] a, input logic [LW-1:0] b,
                                             input logic mode, input int k);
    logic [PBW-1:0] p;
    logic [31:0]    r;
    p = '0;
    for (int c = 0; c < CH; c++) begin
      r = approx_mult(16'(a[c*W +: W]), 16'(b[c*W +: W]), mode ? k : 0);
      p[c*2*W +: 2*W] = r[2*W-1:0];
    end
    return p;
  endfunction

  function automatic logic [PBW-1:0] exact_bus(input logic [LW-1:0] a, input logic [LW-1:0] b);
    logic [PBW-1:0] p;
    for (int c = 0; c < CH; c++) p[c*2*W +: 2*W] = 16'(a[c*W +: W]) * 16'(b[c*W +: W]);
    return p;
  endfunction

  function automatic logic [LW-1:0] model_msb(input logic [PBW-1:0] p);
    logic [LW-1:0] m;
    for (int c = 0; c < CH; c++) m[c*W +: W] = p[c*2*W + W +: W];
    return m;
  endfunction

  // Observe the handshakes that will happen at the coming edge.
  task automatic sb_step();
    beat_t bt;
    if (rst) begin
      exp_q.delete();
      hold_prev = 1'b0;
      txn_exp   = 0;
      return;
    end
    check_eq("txn_count", 64'(txn_k[MAIN]), 64'(txn_exp));
    if (hold_prev) begin
      check_eq("hold_p", 64'(out_p_k[MAIN]), 64'(prev_p));
      check_eq("hold_mode", 64'(out_mode_k[MAIN]), 64'(prev_mode));
    end
    hold_prev = out_valid_k[MAIN] && !out_ready;
    prev_p    = out_p_k[MAIN];
    prev_mode = out_mode_k[MAIN];
    if (out_valid_k[MAIN] && out_ready) begin
      check_eq("beat_expected", 64'(exp_q.size() != 0), 64'd1);
      if (exp_q.size() != 0) begin
        bt = exp_q.pop_front();
        for (int k = 0; k < NK; k++) begin
          check_eq($sformatf("p_k%0d", k), 64'(out_p_k[k]), 64'(model_p(bt.a, bt.b, bt.mode, k)));
          check_eq($sformatf("msb_k%0d", k), 64'(out_msb_k[k]), 64'(model_msb(model_p(bt.a, bt.b, bt.mode, k))));
        end
        check_eq("k0_exact", 64'(out_p_k[0]), 64'(exact_bus(bt.a, bt.b)));
        check_eq("out_mode", 64'(out_mode_k[MAIN]), 64'(bt.mode));
      end
      txn_exp++;
    end
    if (in_valid && in_ready_k[MAIN]) begin
      exp_q.push_back('{a: in_a, b: in_b, mode: in_mode});
      accepts++;
    end
  endtask

  task automatic cyc(input logic v, input logic [LW-1:0] a, input logic [LW-1:0] b,
                     input logic m, input logic r);
    @(negedge clk);
    in_valid  = v;
    in_a      = a;
    in_b      = b;
    in_mode   = m;
    out_ready = r;
    #1;
    sb_step();
  endtask

  function automatic logic [LW-1:0] rand_op();
    logic [LW-1:0] v;
    v = LW'($urandom);
    if ($urandom_range(0, 7) == 0) v = '1;
    return v;
  endfunction

  logic [LW-1:0]  opv;
  logic [PBW-1:0] held;
  int             acc;
  int             cycles;

  initial begin
    rst = 1'b1; in_valid = 1'b0; in_a = '0; in_b = '0; in_mode = 1'b0; out_ready = 1'b0;

    // Reset state
    cyc(1'b0, '0, '0, 1'b0, 1'b1);
    cyc(1'b0, '0, '0, 1'b0, 1'b1);
    check_eq("rst_out_valid", 64'(out_valid_k[MAIN]), 64'd0);
    check_eq("rst_txn", 64'(txn_k[MAIN]), 64'd0);
    check_eq("rst_out_p", 64'(out_p_k[MAIN]), 64'd0);
    check_eq("rst_out_msb", 64'(out_msb_k[MAIN]), 64'd0);
    check_eq("rst_out_mode", 64'(out_mode_k[MAIN]), 64'd0);
    check_eq("rst_in_ready", 64'(in_ready_k[MAIN]), 64'd1);
    rst = 1'b0;

    // Known products, latency and back-to-back order (lanes: 0xFF, 0x03, 0x10)
    opv = 24'h1003FF;
    cyc(1'b1, opv, opv, 1'b1, 1'b1);
    check_eq("idle_in_ready", 64'(in_ready_k[MAIN]), 64'd1);
    cyc(1'b1, opv, opv, 1'b0, 1'b1);
    check_eq("lat_not_yet", 64'(out_valid_k[MAIN]), 64'd0);
    cyc(1'b1, rand_op(), rand_op(), 1'b1, 1'b1);
    check_eq("lat_valid", 64'(out_valid_k[MAIN]), 64'd1);
    check_eq("apx_ff", 64'(out_p_k[MAIN][15:0]), 64'hF7FF);
    check_eq("apx_ff_msb", 64'(out_msb_k[MAIN][7:0]), 64'hF7);
    check_eq("apx_03", 64'(out_p_k[MAIN][31:16]), 64'h0007);
    check_eq("apx_10", 64'(out_p_k[MAIN][47:32]), 64'h0100);
    check_eq("apx_mode", 64'(out_mode_k[MAIN]), 64'd1);
    cyc(1'b0, '0, '0, 1'b0, 1'b1);
    check_eq("exa_ff", 64'(out_p_k[MAIN][15:0]), 64'hFE01);
    check_eq("exa_ff_msb", 64'(out_msb_k[MAIN][7:0]), 64'hFE);
    check_eq("exa_03", 64'(out_p_k[MAIN][31:16]), 64'h0009);
    check_eq("exa_10", 64'(out_p_k[MAIN][47:32]), 64'h0100);
    check_eq("exa_mode", 64'(out_mode_k[MAIN]), 64'd0);
    cyc(1'b0, '0, '0, 1'b0, 1'b1);
    check_eq("third_valid", 64'(out_valid_k[MAIN]), 64'd1);
    cyc(1'b0, '0, '0, 1'b0, 1'b1);
    check_eq("b2b_drained", 64'(out_valid_k[MAIN]), 64'd0);
    check_eq("b2b_txn", 64'(txn_k[MAIN]), 64'd3);

    // Backpressure: five offers with out_ready low, only two fit
    acc = 0;
    for (int i = 0; i < 5; i++) begin
      cyc(1'b1, rand_op(), rand_op(), 1'($urandom), 1'b0);
      if (in_ready_k[MAIN]) acc++;
      if (i == 2) held = out_p_k[MAIN];
    end
    check_eq("bp_accepts", 64'(acc), 64'd2);
    check_eq("bp_in_ready_low", 64'(in_ready_k[MAIN]), 64'd0);
    check_eq("bp_held", 64'(out_p_k[MAIN]), 64'(held));
    for (int i = 0; i < 3; i++) cyc(1'b0, '0, '0, 1'b0, 1'b1);
    check_eq("bp_drained", 64'(out_valid_k[MAIN]), 64'd0);
    check_eq("bp_txn", 64'(txn_k[MAIN]), 64'd5);

    // Reset with two beats in flight
    cyc(1'b1, rand_op(), rand_op(), 1'b1, 1'b1);
    cyc(1'b1, rand_op(), rand_op(), 1'b0, 1'b1);
    rst = 1'b1;
    cyc(1'b0, '0, '0, 1'b0, 1'b1);
    rst = 1'b0;
    cyc(1'b0, '0, '0, 1'b0, 1'b1);
    check_eq("mid_rst_valid", 64'(out_valid_k[MAIN]), 64'd0);
    check_eq("mid_rst_txn", 64'(txn_k[MAIN]), 64'd0);
    for (int i = 0; i < 4; i++) begin
      cyc(1'b0, '0, '0, 1'b0, 1'b1);
      check_eq("no_stale_beat", 64'(out_valid_k[MAIN]), 64'd0);
    end

    // Random traffic with random backpressure
    accepts = 0;
    cycles  = 0;
    while (accepts < 10000 && cycles < 60000) begin
      cyc(1'($urandom_range(0, 3) != 0), rand_op(), rand_op(), 1'($urandom),
          1'($urandom_range(0, 9) < 7));
      cycles++;
    end
    check_eq("random_accepts", 64'(accepts >= 10000), 64'd1);
    while (exp_q.size() != 0 && cycles < 70000) begin
      cyc(1'b0, '0, '0, 1'b0, 1'b1);
      cycles++;
    end
    check_eq("drain_empty", 64'(exp_q.size()), 64'd0);
    cyc(1'b0, '0, '0, 1'b0, 1'b1);
    check_eq("final_idle", 64'(out_valid_k[MAIN]), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
